// File: rtl/approx_acc_pkg.sv
// Shared types and defaults for the approximate-product accumulator.
// Holds the FSM state encoding, default widths and the saturation ceiling helper.
package approx_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int PROD_W_DEF  = 16;
    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;

    // All-ones value of a w-bit unsigned quantity (w up to 63).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: W-bit accumulator plus zero-extended IN_W-bit operand.
// The sum is formed at W+1 bits; bit W is the carry that triggers the clamp.
module sat_add_u
    import approx_acc_pkg::*;
#(
    parameter int W    = ACC_W_DEF,
    parameter int IN_W = PROD_W_DEF
) (
    input  logic [W-1:0]    a_i,
    input  logic [IN_W-1:0] b_i,
    output logic [W-1:0]    sum_o,
    output logic            ovf_o
);

    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));

    logic [W:0] full;

    assign full  = {1'b0, a_i} + {{(W + 1 - IN_W){1'b0}}, b_i};
    assign ovf_o = full[W];
    assign sum_o = full[W] ? SAT_MAX : full[W-1:0];

endmodule

// File: rtl/approx_prod_accumulator.sv
// Accumulates a packet of multiplier products into a saturating sum and
// returns sum, beat count and overflow/truncation flags over valid/ready.
module approx_prod_accumulator
    import approx_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_truncated
);

    // Handshake: a beat moves when in_valid && in_ready; a result moves when
    // out_valid && out_ready. in_ready only drops while a result is stuck.
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_out_q, ovf_out_d;
    logic               trunc_q, trunc_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               accept, handshake, start_new, close;
    logic [ACC_W-1:0]   acc_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               ovf_n;

    sat_add_u #(
        .W    (ACC_W),
        .IN_W (PROD_W)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign in_ready  = !rst && ((state_q != HOLD) || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;
    // Outside ACCUM an accepted beat always opens a fresh packet.
    assign start_new = (state_q != ACCUM);
    assign acc_n     = start_new ? ACC_W'(in_data) : add_sum;
    assign cnt_n     = start_new ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign ovf_n     = start_new ? 1'b0 : (ovf_q | add_ovf);
    assign close     = in_last || (cnt_n == CNT_W'(MAX_LEN));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        count_d     = count_q;
        ovf_out_d   = ovf_out_q;
        trunc_d     = trunc_q;

        if (handshake) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end

        if (accept) begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            ovf_d = ovf_n;
            if (close) begin
                out_valid_d = 1'b1;
                sum_d       = acc_n;
                count_d     = cnt_n;
                ovf_out_d   = ovf_n;
                trunc_d     = !in_last;
                state_d     = HOLD;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            count_q     <= '0;
            ovf_out_q   <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            ovf_out_q   <= ovf_out_d;
            trunc_q     <= trunc_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_sum       = sum_q;
    assign out_count     = count_q;
    assign out_overflow  = ovf_out_q;
    assign out_truncated = trunc_q;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Directed bench for approx_prod_accumulator: a default-width instance and an
// 18-bit-accumulator instance share the same stimulus.
module tb_approx_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_overflow, out_truncated;
    logic [23:0] out_sum;
    logic [8:0]  out_count;

    logic        in_ready18, out_valid18, out_overflow18, out_truncated18;
    logic [17:0] out_sum18;
    logic [8:0]  out_count18;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    approx_prod_accumulator dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_count     (out_count),
        .out_overflow  (out_overflow),
        .out_truncated (out_truncated)
    );

    approx_prod_accumulator #(.ACC_W(18)) dut18 (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready18),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid18),
        .out_ready     (out_ready),
        .out_sum       (out_sum18),
        .out_count     (out_count18),
        .out_overflow  (out_overflow18),
        .out_truncated (out_truncated18)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one clock, then drop in_valid.
    task automatic beat(input logic [15:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_flags", {out_overflow, out_truncated}, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Three-beat packet, immediate handshake
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        chk("mid_pkt_no_valid", out_valid, 0);
        beat(16'd300, 1'b1);
        chk("p3_valid", out_valid, 1);
        chk("p3_sum", out_sum, 600);
        chk("p3_count", out_count, 3);
        chk("p3_flags", {out_overflow, out_truncated}, 0);
        step();
        chk("p3_valid_drop", out_valid, 0);
        chk("p3_sum_kept", out_sum, 600);

        // Five beats of 65025: saturates the 18-bit instance only
        for (int i = 0; i < 4; i++) beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b1);
        chk("sat18_valid", out_valid18, 1);
        chk("sat18_sum", out_sum18, 262143);
        chk("sat18_ovf", out_overflow18, 1);
        chk("sat18_count", out_count18, 5);
        chk("sat18_trunc", out_truncated18, 0);
        chk("sat24_sum", out_sum, 325125);
        chk("sat24_ovf", out_overflow, 0);
        step();

        // MAX_LEN force-close, then a back-to-back single-beat packet
        for (int i = 0; i < 255; i++) beat(16'd1, 1'b0);
        chk("trunc_not_yet", out_valid, 0);
        beat(16'd1, 1'b0);
        chk("trunc_valid", out_valid, 1);
        chk("trunc_sum", out_sum, 256);
        chk("trunc_count", out_count, 256);
        chk("trunc_flag", out_truncated, 1);
        chk("trunc_ovf", out_overflow, 0);
        beat(16'd9, 1'b1);
        chk("fresh_valid", out_valid, 1);
        chk("fresh_sum", out_sum, 9);
        chk("fresh_count", out_count, 1);
        chk("fresh_trunc", out_truncated, 0);
        step();
        chk("fresh_valid_drop", out_valid, 0);

        // Back-pressure: result held, beat waits, then both move together
        out_ready = 1'b0;
        beat(16'd50, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'd7;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 50);
            chk("hold_count", out_count, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("hs_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("hs_valid", out_valid, 1);
        chk("hs_sum", out_sum, 7);
        chk("hs_count", out_count, 1);
        step();
        chk("hs_valid_drop", out_valid, 0);

        // Reset mid-packet discards everything
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        step();
        beat(16'd5, 1'b1);
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_sum", out_sum, 5);
        chk("after_rst_count", out_count, 1);
        step();

        // Single full-scale beat
        beat(16'd65535, 1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_sum", out_sum, 65535);
        chk("single_count", out_count, 1);
        chk("single_flags", {out_overflow, out_truncated}, 0);
        step();
        chk("single_valid_drop", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
